disp_out_ctrl: RTL and testbench

Parametrised display-output controller for the calculator datapath. It sits between the operand/result registers and the 7-segment decoders. It holds NUM_CH channel values in a shadow register and reveals channels progressively according to the calculator stage. It drives per-digit blanking and blinks all visible digits while an error is flagged. All outputs are registered on the rising edge of clk.

---
 rtl/disp_out_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_disp_out_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_out_ctrl.sv
// -----------------------------------------------------------------------------
// disp_out_ctrl
//
// Display-output controller between the calculator's operand/result registers
// and the 7-segment decoders. NUM_CH channel values are held in a shadow
// register; channels are revealed progressively by the calculator stage, each
// hex digit gets a blanking bit, and all visible digits blink while an error
// is flagged. Every output is a flop clocked on the rising edge of clk.
//
// Parameters:
//   NUM_CH    - number of display channels (>= 2)
//   DATA_W    - bits per channel, multiple of 4; DIGITS = DATA_W/4
//   BLINK_DIV - clock cycles per blink half-period (>= 1)
//   SEL_W     - width of stage_i; 2**SEL_W must exceed NUM_CH
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous reset, active-low
//   stage_i    - reveal stage: k < NUM_CH shows channels 0..k, k >= NUM_CH
//                shows nothing
//   din_i      - channel values, channel i at din_i[i*DATA_W +: DATA_W]
//   din_vld_i  - capture din_i into the shadow register at the clock edge
//   err_i      - error flag; visible digits blink while high
//   dout_o     - displayed values, same packing as din_i
//   blank_o    - 1 = digit off; bit i*DIGITS+j is digit j of channel i
//   blink_ph_o - current blink phase, 1 = digits on
//
// Build option:
//   DISP_LZ_BLANK_EN - when defined, leading zero digits of visible channels
//                      are blanked (digit 0 always stays on).
// -----------------------------------------------------------------------------
module disp_out_ctrl #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BLINK_DIV = 4,
    parameter int unsigned SEL_W     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [SEL_W-1:0]                 stage_i,
    input  logic [NUM_CH*DATA_W-1:0]         din_i,
    input  logic                             din_vld_i,
    input  logic                             err_i,
    output logic [NUM_CH*DATA_W-1:0]         dout_o,
    output logic [NUM_CH*(DATA_W/4)-1:0]     blank_o,
    output logic                             blink_ph_o
);

    localparam int unsigned DIGITS = DATA_W / 4;
    localparam int unsigned CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        StShow,
        StErrOn,
        StErrOff
    } blink_st_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_CH*DATA_W-1:0]     shadow_q, shadow_d;
    logic [NUM_CH*DATA_W-1:0]     dout_q, dout_d;
    logic [NUM_CH*DIGITS-1:0]     blank_q, blank_d;
    blink_st_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         blink_ph_q, blink_ph_d;

    // Combinational helpers
    logic [NUM_CH-1:0]            vis;
    logic [NUM_CH*DIGITS-1:0]     blank_pre;
    int unsigned                  stage_u;

    // -------------------------------------------------------------------------
    // Shadow register
    // -------------------------------------------------------------------------
    always_comb begin
        shadow_d = shadow_q;
        if (din_vld_i) begin
            shadow_d = din_i;
        end
    end

    // -------------------------------------------------------------------------
    // Blink FSM: err_i low always returns to StShow with the counter cleared.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!err_i) begin
            state_d = StShow;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StShow: begin
                    state_d = StErrOn;
                    cnt_d   = '0;
                end
                StErrOn: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = StErrOff;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StErrOff: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = StErrOn;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            endcase
        end
        // Phase tracks the next state so blank_o and blink_ph_o change together.
        blink_ph_d = (state_d != StErrOff);
    end

    // -------------------------------------------------------------------------
    // Visibility: reserved stage values (>= NUM_CH) hide every channel.
    // -------------------------------------------------------------------------
    always_comb begin
        stage_u = 32'(stage_i);
        vis     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            vis[i] = (stage_u < NUM_CH) && (i <= stage_u);
        end
    end

    // -------------------------------------------------------------------------
    // Output data and blanking. Both use the shadow as it was before this edge,
    // so data captured together with a stage change shows one edge later.
    // -------------------------------------------------------------------------
`ifdef DISP_LZ_BLANK_EN
    logic hi_zero;
`endif

    always_comb begin
        dout_d    = '0;
        blank_pre = '1;
`ifdef DISP_LZ_BLANK_EN
        hi_zero   = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (vis[i]) begin
                dout_d[i*DATA_W +: DATA_W]    = shadow_q[i*DATA_W +: DATA_W];
                blank_pre[i*DIGITS +: DIGITS] = '0;
`ifdef DISP_LZ_BLANK_EN
                // Walk down from the top nibble; a digit is suppressed while
                // it and everything above it is zero. Digit 0 never is.
                hi_zero = 1'b1;
                for (int j = int'(DIGITS) - 1; j >= 1; j--) begin
                    hi_zero = hi_zero && (shadow_q[i*DATA_W + 4*j +: 4] == 4'h0);
                    blank_pre[i*DIGITS + j] = hi_zero;
                end
`endif
            end
        end
        // Blink mask applied last: off phase blanks every digit, dout untouched.
        blank_d = blink_ph_d ? blank_pre : '1;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            dout_q     <= '0;
            blank_q    <= '1;
            state_q    <= StShow;
            cnt_q      <= '0;
            blink_ph_q <= 1'b1;
        end else begin
            shadow_q   <= shadow_d;
            dout_q     <= dout_d;
            blank_q    <= blank_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blink_ph_q <= blink_ph_d;
        end
    end

    assign dout_o     = dout_q;
    assign blank_o    = blank_q;
    assign blink_ph_o = blink_ph_q;

endmodule

// File: tb/tb_disp_out_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_out_ctrl
//
// Self-checking bench for disp_out_ctrl at default parameters. A reference
// model tracks the shadow value and the length of the current err run; the
// blink phase is derived from the run length, and blanking from the number of
// significant hex digits of each visible channel.
// -----------------------------------------------------------------------------
module tb_disp_out_ctrl;

    localparam int NUM_CH    = 3;
    localparam int DATA_W    = 8;
    localparam int DIGITS    = DATA_W / 4;
    localparam int BLINK_DIV = 4;
    localparam int SEL_W     = 2;
    localparam int DW        = NUM_CH * DATA_W;
    localparam int BW        = NUM_CH * DIGITS;

    logic             clk;
    logic             rst_n;
    logic [SEL_W-1:0] stage;
    logic [DW-1:0]    din;
    logic             din_vld;
    logic             err;
    logic [DW-1:0]    dout;
    logic [BW-1:0]    blank;
    logic             blink_ph;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [DW-1:0] m_shadow;
    int            m_run;
    logic [DW-1:0] exp_dout;
    logic [BW-1:0] exp_blank;
    logic          exp_ph;

    disp_out_ctrl #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .BLINK_DIV(BLINK_DIV),
        .SEL_W    (SEL_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stage_i   (stage),
        .din_i     (din),
        .din_vld_i (din_vld),
        .err_i     (err),
        .dout_o    (dout),
        .blank_o   (blank),
        .blink_ph_o(blink_ph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of hex digits needed to print v (a zero value still shows one).
    function automatic int sig_digits(input logic [DATA_W-1:0] v);
        int n;
        n = 1;
        for (int j = 0; j < DIGITS; j++) begin
            if (((v >> (4 * j)) & 'hF) != 0) n = j + 1;
        end
        return n;
    endfunction

    // Drive one cycle of inputs, advance one edge, update model expectations.
    task automatic tick(input logic [SEL_W-1:0] st, input logic [DW-1:0] d,
                        input logic v, input logic e);
        logic [DATA_W-1:0] chv;
        int                sig;
        stage   = st;
        din     = d;
        din_vld = v;
        err     = e;
        @(posedge clk);
        m_run  = e ? m_run + 1 : 0;
        exp_ph = (m_run == 0) ? 1'b1 : ((((m_run - 1) / BLINK_DIV) % 2) == 0);
        exp_dout  = '0;
        exp_blank = '1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (int'(st) < NUM_CH && ch <= int'(st)) begin
                chv = m_shadow[ch*DATA_W +: DATA_W];
                exp_dout[ch*DATA_W +: DATA_W] = chv;
`ifdef DISP_LZ_BLANK_EN
                sig = sig_digits(chv);
`else
                sig = DIGITS;
`endif
                for (int j = 0; j < DIGITS; j++) exp_blank[ch*DIGITS + j] = (j >= sig);
            end
        end
        if (!exp_ph) exp_blank = '1;
        if (v) m_shadow = d;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stage = 2'd2; din = '0; din_vld = 1'b0; err = 1'b0;
        m_shadow = '0; m_run = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dout !== '0 || blank !== '1 || blink_ph !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init: dout=%h blank=%b ph=%b, want 0/%b/1",
                     dout, blank, blink_ph, {BW{1'b1}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2'd2, 24'h03257A, 1'b1, 1'b0);
        tick(2'd2, 24'h03257A, 1'b0, 1'b1);
        tick(2'd2, 24'h03257A, 1'b0, 1'b1);
        n_tests++;
        if (dout !== 24'h03257A) begin
            n_fail++;
            $display("FAIL reset_preload: dout=%h want 03257a", dout);
        end
        // Assert reset between edges, mid-blink
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dout !== '0 || blank !== '1 || blink_ph !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: dout=%h blank=%b ph=%b, want 0/%b/1",
                     dout, blank, blink_ph, {BW{1'b1}});
        end
        m_shadow = '0; m_run = 0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load();
        tick(2'd0, {8'h03, 8'h25, 8'h7A}, 1'b1, 1'b0);
        tick(2'd0, 24'h0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 24'h00007A || blank !== 6'b111100 || dout !== exp_dout) begin
            n_fail++;
            $display("FAIL load: dout=%h blank=%b, want 00007a/111100", dout, blank);
        end
    endtask

    task automatic test_stage();
        logic [BW-1:0] want;
`ifdef DISP_LZ_BLANK_EN
        want = 6'b100000;
`else
        want = 6'b000000;
`endif
        tick(2'd1, 24'h0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 24'h00257A || blank !== 6'b110000) begin
            n_fail++;
            $display("FAIL stage1: dout=%h blank=%b, want 00257a/110000", dout, blank);
        end
        tick(2'd2, 24'h0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 24'h03257A || blank !== want) begin
            n_fail++;
            $display("FAIL stage2: dout=%h blank=%b, want 03257a/%b", dout, blank, want);
        end
    endtask

    task automatic test_reserved();
        tick(2'd3, 24'hFFFFFF, 1'b0, 1'b0);
        n_tests++;
        if (dout !== '0 || blank !== 6'b111111) begin
            n_fail++;
            $display("FAIL reserved: dout=%h blank=%b, want 0/111111", dout, blank);
        end
        tick(2'd2, 24'h123456, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 24'h03257A) begin
            n_fail++;
            $display("FAIL shadow_hold: dout=%h want 03257a", dout);
        end
    endtask

    task automatic test_blink();
        logic [BW-1:0] on_blank;
`ifdef DISP_LZ_BLANK_EN
        on_blank = 6'b100000;
`else
        on_blank = 6'b000000;
`endif
        for (int k = 0; k < 20; k++) begin
            tick(2'd2, 24'h0, 1'b0, 1'b1);
            n_tests++;
            if (dout !== 24'h03257A || blank !== exp_blank || blink_ph !== exp_ph) begin
                n_fail++;
                $display("FAIL blink[%0d]: dout=%h blank=%b ph=%b, want 03257a/%b/%b",
                         k, dout, blank, blink_ph, exp_blank, exp_ph);
            end
        end
        tick(2'd2, 24'h0, 1'b0, 1'b0);
        n_tests++;
        if (blank !== on_blank || blink_ph !== 1'b1) begin
            n_fail++;
            $display("FAIL blink_exit: blank=%b ph=%b, want %b/1", blank, blink_ph, on_blank);
        end
        // BLINK_DIV digits on then off: check the cadence at the phase edges
        tick(2'd2, 24'h0, 1'b0, 1'b1);
        repeat (BLINK_DIV - 1) tick(2'd1, 24'h0, 1'b0, 1'b1);
        n_tests++;
        if (blink_ph !== 1'b1) begin
            n_fail++;
            $display("FAIL blink_on_len: ph=%b want 1", blink_ph);
        end
        tick(2'd0, 24'h0, 1'b0, 1'b1);
        n_tests++;
        if (blink_ph !== 1'b0 || blank !== 6'b111111 || dout !== 24'h00007A) begin
            n_fail++;
            $display("FAIL blink_off: ph=%b blank=%b dout=%h, want 0/111111/00007a",
                     blink_ph, blank, dout);
        end
        tick(2'd0, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic test_lz();
`ifdef DISP_LZ_BLANK_EN
        tick(2'd2, {8'h10, 8'h0F, 8'h00}, 1'b1, 1'b0);
        tick(2'd2, 24'h0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 24'h100F00 || blank !== 6'b001010) begin
            n_fail++;
            $display("FAIL lz: dout=%h blank=%b, want 100f00/001010", dout, blank);
        end
`else
        tick(2'd2, {8'h10, 8'h0F, 8'h00}, 1'b1, 1'b0);
        tick(2'd2, 24'h0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 24'h100F00 || blank !== 6'b000000) begin
            n_fail++;
            $display("FAIL no_lz: dout=%h blank=%b, want 100f00/000000", dout, blank);
        end
`endif
    endtask

    task automatic test_random();
        logic e;
        e = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 11) == 0) e = ~e;
            tick(SEL_W'($urandom_range(0, 3)), DW'($urandom),
                 ($urandom_range(0, 2) == 0), e);
            n_tests++;
            if (dout !== exp_dout || blank !== exp_blank || blink_ph !== exp_ph) begin
                n_fail++;
                $display("FAIL random[%0d]: dout=%h blank=%b ph=%b, want %h/%b/%b",
                         k, dout, blank, blink_ph, exp_dout, exp_blank, exp_ph);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_load();
        test_stage();
        test_reserved();
        test_blink();
        test_lz();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
